// File: rtl/cart_pkg.sv
// cart_pkg -- shared constants and helpers for the Atari-style bank-switched
// cartridge controller.
//
// Contents:
//   hotspot_base()  first hotspot address for a given NBANK_LOG2
//   hotspot_limit() last hotspot address for a given NBANK_LOG2
//   reset_bank()    bank selected out of reset (the highest bank)
//   SC_RAM_SIZE     Superchip RAM depth in bytes
//   SC_WR_LO/HI     Superchip write window (console address)
//   SC_RD_LO/HI     Superchip read window (console address)
package cart_pkg;

  localparam int SC_RAM_SIZE = 128;
  localparam int SC_AW       = $clog2(SC_RAM_SIZE);

  localparam logic [11:0] SC_WR_LO = 12'h000;
  localparam logic [11:0] SC_WR_HI = 12'h07F;
  localparam logic [11:0] SC_RD_LO = 12'h080;
  localparam logic [11:0] SC_RD_HI = 12'h0FF;

  // F8 = 2 banks, F6 = 4 banks, F4 = 8 banks. The hotspot block always ends
  // at FF9 or FFB and holds exactly one address per bank.
  function automatic logic [11:0] hotspot_base(input int nbank_log2);
    case (nbank_log2)
      1:       return 12'hFF8;
      2:       return 12'hFF6;
      3:       return 12'hFF4;
      default: return 12'hFF8;
    endcase
  endfunction

  function automatic logic [11:0] hotspot_limit(input int nbank_log2);
    case (nbank_log2)
      1:       return 12'hFF9;
      2:       return 12'hFF9;
      3:       return 12'hFFB;
      default: return 12'hFF9;
    endcase
  endfunction

  // Cartridges boot from the last bank, which holds the reset vector.
  function automatic int reset_bank(input int nbank_log2);
    return (1 << nbank_log2) - 1;
  endfunction

endpackage

// File: rtl/cart_sc_ram.sv
// cart_sc_ram -- 128-byte Superchip RAM: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset so that a
// console reset preserves game state.
//
// Ports:
//   clk    clock
//   we     write enable (write happens on rising edge)
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational)
module cart_sc_ram
  import cart_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [SC_AW-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [SC_AW-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [SC_RAM_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cart_bank_ctrl.sv
// cart_bank_ctrl -- bank-switch controller for F8/F6/F4 cartridges with an
// optional Superchip RAM, compiled in only when macro CART_SC_RAM_EN is
// defined.
//
// Ports:
//   MCLK      machine clock, all state on rising edge
//   RES_N     synchronous active-low reset
//   CS        cartridge select (console address bit 12)
//   ADDR      console cartridge address [11:0]
//   D_WR      console CPU data-out bus
//   ROM_D     data from external ROM
//   ROM_ADDR  external ROM address = {BANK, ADDR}
//   D_OUT     data returned to console
//   BANK      current bank register
//
// Bus qualification: there is no valid/ready handshake. Each cycle with CS=1
// is a bus cycle; a new access is one where CS just rose or ADDR changed
// while CS stayed high, so an access stretched over several cycles (RDY
// stall) is treated as a single access.
module cart_bank_ctrl
  import cart_pkg::*;
#(
  parameter int NBANK_LOG2 = 1
) (
  input  logic                   MCLK,
  input  logic                   RES_N,
  input  logic                   CS,
  input  logic [11:0]            ADDR,
  input  logic [7:0]             D_WR,
  input  logic [7:0]             ROM_D,
  output logic [NBANK_LOG2+11:0] ROM_ADDR,
  output logic [7:0]             D_OUT,
  output logic [NBANK_LOG2-1:0]  BANK
);

  localparam logic [11:0] HS_BASE  = hotspot_base(NBANK_LOG2);
  localparam logic [11:0] HS_LIMIT = hotspot_limit(NBANK_LOG2);
  localparam logic [NBANK_LOG2-1:0] HS_BASE_LO = HS_BASE[NBANK_LOG2-1:0];
  localparam logic [NBANK_LOG2-1:0] RST_BANK =
    NBANK_LOG2'(reset_bank(NBANK_LOG2));

  logic                  prev_cs;
  logic [11:0]           prev_addr;
  logic                  new_access;
  logic                  in_hotspot;
  logic [NBANK_LOG2-1:0] hs_bank;

  assign new_access = CS && (!prev_cs || (ADDR != prev_addr));
  assign in_hotspot = (ADDR >= HS_BASE) && (ADDR <= HS_LIMIT);
  // Bank index is the offset into the hotspot block; only the low bits
  // matter because the block holds exactly 2^NBANK_LOG2 addresses.
  assign hs_bank    = ADDR[NBANK_LOG2-1:0] - HS_BASE_LO;

  always_ff @(posedge MCLK) begin
    if (!RES_N) begin
      BANK      <= RST_BANK;
      prev_cs   <= 1'b0;
      prev_addr <= 12'h000;
    end else begin
      prev_cs   <= CS;
      prev_addr <= ADDR;
      if (new_access && in_hotspot) BANK <= hs_bank;
    end
  end

  // The switch lands on the edge, so the triggering cycle still sees the
  // old bank here.
  assign ROM_ADDR = {BANK, ADDR};

`ifdef CART_SC_RAM_EN
  logic       ram_we;
  logic       ram_rd;
  logic [7:0] ram_rdata;

  assign ram_we = CS && (ADDR >= SC_WR_LO) && (ADDR <= SC_WR_HI);
  assign ram_rd = CS && (ADDR >= SC_RD_LO) && (ADDR <= SC_RD_HI);

  cart_sc_ram u_sc_ram (
    .clk   (MCLK),
    .we    (ram_we),
    .waddr (ADDR[SC_AW-1:0]),
    .wdata (D_WR),
    .raddr (ADDR[SC_AW-1:0]),
    .rdata (ram_rdata)
  );

  // The write window reads back as open bus (all ones).
  always_comb begin
    D_OUT = ROM_D;
    if (ram_rd)      D_OUT = ram_rdata;
    else if (ram_we) D_OUT = 8'hFF;
  end
`else
  logic unused_d_wr;
  assign unused_d_wr = ^D_WR;
  assign D_OUT       = ROM_D;
`endif

endmodule

// File: doc/cart_bank_ctrl.md
CART_BANK_CTRL -- requirements
Module: cart_bank_ctrl

Interface
REQ-001 SHALL provide parameter NBANK_LOG2, default 1, log2 of ROM bank count: 1=F8 (2x4KB), 2=F6 (4x4KB), 3=F4 (8x4KB).
REQ-002 SHALL have port MCLK input 1: machine clock; the single clock, all state updates on rising edge.
REQ-003 SHALL have port RES_N input 1: reset, synchronous, active-low.
REQ-004 SHALL have port CS input 1: cartridge select from console (address bit 12).
REQ-005 SHALL have port ADDR input 12: console cartridge address.
REQ-006 SHALL have port D_WR input 8: console CPU data-out bus.
REQ-007 SHALL have port ROM_D input 8: data from external ROM.
REQ-008 SHALL have port ROM_ADDR output NBANK_LOG2+12: external ROM address.
REQ-009 SHALL have port D_OUT output 8: data returned to console data-in.
REQ-010 SHALL have port BANK output NBANK_LOG2: current bank register.

Function
REQ-011 SHALL drive ROM_ADDR = {BANK, ADDR} combinationally.
REQ-012 SHALL define new_access = CS && (!prev_cs || ADDR != prev_addr); prev_cs/prev_addr are CS/ADDR registered every cycle.
REQ-013 SHALL use hotspots F8: FF8-FF9 -> bank 0-1; F6: FF6-FF9 -> bank 0-3; F4: FF4-FFB -> bank 0-7.
REQ-014 SHALL load BANK with the hotspot's bank on the edge ending a cycle with new_access and ADDR in the hotspot range; one switch per access.
REQ-015 SHALL ignore a hotspot address held for further cycles (RDY stall) -- no repeated switch, BANK stable.
REQ-016 SHALL ignore hotspot addresses while CS=0.
REQ-017 SHALL use the pre-switch BANK for ROM_ADDR during the triggering cycle; the new bank appears the next cycle.
REQ-018 SHALL re-trigger when CS drops for >=1 cycle and the same hotspot is addressed again.
REQ-019 SHALL drive D_OUT = ROM_D whenever no RAM window applies (REQ-022).

Reset
REQ-020 SHALL, on an edge with RES_N=0, set BANK = 2^NBANK_LOG2-1, prev_cs=0, prev_addr=0; reset mid-access discards any pending switch; first cycle after release with CS=1 counts as new_access.

Configuration
REQ-021 SHALL compile 128-byte Superchip RAM only when macro CART_SC_RAM_EN is defined.
REQ-022 With CART_SC_RAM_EN: each cycle with CS=1 and ADDR 000-07F writes D_WR to RAM[ADDR[6:0]] (last cycle of a held access wins); CS=1 and ADDR 080-0FF reads D_OUT = RAM[ADDR[6:0]] combinationally; ADDR 000-07F reads D_OUT = 8'hFF; RAM not cleared by reset; RAM accesses never affect BANK.
REQ-023 Without CART_SC_RAM_EN: no RAM storage; D_OUT = ROM_D for all addresses.

Structure
REQ-024 SHALL place hotspot base/limit constants per NBANK_LOG2, reset-bank function, RAM size (128) and window bounds in shared package cart_pkg.
REQ-025 SHALL isolate Superchip storage in sub-module cart_sc_ram (write port, async read port), instantiated only under CART_SC_RAM_EN.

Verification
REQ-026 Reset, NBANK_LOG2=1: RES_N=0 one edge -> BANK=1, ROM_ADDR=13'h1000 for ADDR=000, CS=1.
REQ-027 F6: CS=1, ADDR=FF7 held 3 cycles -> BANK=1 from cycle 2 on, exactly one update; triggering-cycle ROM_ADDR uses old bank 3.
REQ-028 F4: ADDR=FFB with CS=0 -> BANK unchanged; then CS=1, ADDR=FF4 -> BANK=0 next cycle; then FFB -> BANK=7.
REQ-029 F8: FF8 access, CS=0 one cycle, FF9, then FF8 -> BANK sequence 0,1,0; back-to-back FF8->FF9 without CS gap also switches to 1.
REQ-030 CART_SC_RAM_EN: write D_WR=8'hA5 at 012, read 092 -> D_OUT=8'hA5; read 012 -> 8'hFF; RES_N pulse then read 092 -> still 8'hA5.
REQ-031 Reset mid-hotspot: RES_N=0 on the triggering cycle of FF8 (F8) -> BANK=1 after reset; FF8 still held after release -> switches to 0 once.
